// File: rtl/div32_pkg.sv
// ============================================================================
// Module      : div32_pkg
// Description : Shared constants and FSM state encoding for divider32_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div32_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_STEPS = 32;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sub32b.sv
// ============================================================================
// Module      : sub32b
// Description : Ripple-chain subtractor d = a - b computed as a + ~b + 1;
//               cout=1 means no borrow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub32b #(
   parameter int WIDTH = 32
) (
   output logic [WIDTH-1:0] d,
   output logic             cout,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b
);

   logic [WIDTH:0]   w_c;
   logic [WIDTH-1:0] w_nb;

   assign w_c[0] = 1'b1;
   assign w_nb   = ~b;

   genvar i;
   for (i = 0; i < WIDTH; i++) begin : g_ripple
      assign d[i]     = a[i] ^ w_nb[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & w_nb[i]) | (a[i] & w_c[i]) | (w_nb[i] & w_c[i]);
   end

   assign cout = w_c[WIDTH];

endmodule

`default_nettype wire

// File: rtl/divider32_seq.sv
// ============================================================================
// Module      : divider32_seq
// Description : Multi-cycle restoring divider, one quotient bit per clock,
//               33-clock start-to-done latency. Define DIV_SIGNED_EN to
//               enable signed division selected by sgn.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider32_seq
   import div32_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sgn,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             dz
);

   localparam logic [CNT_W-1:0] C_STEPS = CNT_W'(DIV_STEPS);

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvs;
   logic             r_dz;
   logic [WIDTH-1:0] r_q_out;
   logic [WIDTH-1:0] r_r_out;
   logic             r_dz_out;

   logic [WIDTH:0]   w_t;
   logic [WIDTH-1:0] w_diff;
   logic             w_cout;
   logic             w_take;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_q_fin;
   logic [WIDTH-1:0] w_r_fin;

   // T is WIDTH+1 bits: a set top bit means T already exceeds any divisor
   assign w_t    = {r_rem, r_quo[WIDTH-1]};
   assign w_take = w_t[WIDTH] | w_cout;

   sub32b #(.WIDTH(WIDTH)) u_sub (
      .d    (w_diff),
      .cout (w_cout),
      .a    (w_t[WIDTH-1:0]),
      .b    (r_dvs)
   );

`ifdef DIV_SIGNED_EN
   logic r_sd;
   logic r_sv;
   logic w_sd;
   logic w_sv;

   assign w_sd    = sgn & dividend[WIDTH-1];
   assign w_sv    = sgn & divisor[WIDTH-1];
   assign w_a     = w_sd ? -dividend : dividend;
   assign w_b     = w_sv ? -divisor  : divisor;
   assign w_q_fin = r_dz ? {WIDTH{1'b1}} : ((r_sd ^ r_sv) ? -r_quo : r_quo);
   assign w_r_fin = r_sd ? -r_rem : r_rem;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sd <= 1'b0;
         r_sv <= 1'b0;
      end else if (r_state == IDLE && start) begin
         r_sd <= w_sd;
         r_sv <= w_sv;
      end
   end
`else
   logic w_unused_sgn;

   assign w_unused_sgn = sgn;
   assign w_a          = dividend;
   assign w_b          = divisor;
   assign w_q_fin      = r_quo;
   assign w_r_fin      = r_rem;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (r_cnt == C_STEPS) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == RUN);
      done = (r_state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_dz     <= 1'b0;
         r_q_out  <= '0;
         r_r_out  <= '0;
         r_dz_out <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_cnt <= '0;
               r_rem <= '0;
               r_quo <= w_a;
               r_dvs <= w_b;
               r_dz  <= (divisor == '0);
            end
            RUN: if (r_cnt != C_STEPS) begin
               r_rem <= w_take ? w_diff : w_t[WIDTH-1:0];
               r_quo <= {r_quo[WIDTH-2:0], w_take};
               r_cnt <= r_cnt + CNT_W'(1);
            end else begin
               r_q_out  <= w_q_fin;
               r_r_out  <= w_r_fin;
               r_dz_out <= r_dz;
            end
            default: ;
         endcase
      end
   end

   assign quotient  = r_q_out;
   assign remainder = r_r_out;
   assign dz        = r_dz_out;

endmodule

`default_nettype wire

// File: tb/tb_divider32_seq.sv
// ============================================================================
// Module      : tb_divider32_seq
// Description : Self-checking bench for divider32_seq against an arithmetic
//               reference model (signed cases only when DIV_SIGNED_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider32_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sgn = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        dz;

   int n_tests = 0;
   int n_fail  = 0;

   divider32_seq dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sgn       (sgn),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .dz        (dz)
   );

   always #5 clk = ~clk;

   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r, output logic z);
      z = (b == 32'd0);
      q = z ? 32'hFFFF_FFFF : a / b;
      r = z ? a : a % b;
`ifdef DIV_SIGNED_EN
      if (s && !z) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
         end else begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
         end
      end
`endif
   endfunction

   // Issues one division from IDLE and returns the delivered result and latency.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] q, output logic [31:0] r, output logic z,
                          output int lat, output bit held);
      logic [31:0] q0;
      logic [31:0] r0;
      q0 = quotient;
      r0 = remainder;
      held = 1'b1;
      lat = 0;
      dividend = a;
      divisor = b;
      sgn = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      dividend = $urandom;
      divisor = $urandom;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            break;
         end
         if (quotient !== q0 || remainder !== r0 || busy !== 1'b1) held = 1'b0;
      end
      q = quotient;
      r = remainder;
      z = dz;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      dividend = 32'd100;
      divisor = 32'd7;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({busy, done, dz, quotient, remainder} !== 67'd0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b dz=%b q=%h r=%h, want all 0",
                  busy, done, dz, quotient, remainder);
      end
      start = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      logic [31:0] va [6] = '{32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd25, 32'd9, 32'd0};
      logic [31:0] vb [6] = '{32'd7, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd3, 32'd5};
      logic [31:0] eq, er, q, r;
      logic ez, z;
      int lat;
      bit held;
      for (int i = 0; i < 6; i++) begin
         model(va[i], vb[i], 1'b0, eq, er, ez);
         run_div(va[i], vb[i], 1'b0, q, r, z, lat, held);
         n_tests++;
         if (q !== eq || r !== er || z !== ez || lat != 33) begin
            n_fail++;
            $display("FAIL directed_%0d: %h/%h got q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b lat=33",
                     i, va[i], vb[i], q, r, z, lat, eq, er, ez);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int n_done = 0;
      int first = 0;
      bit late_busy = 1'b0;
      logic [31:0] q = '0, r = '0;
      dividend = 32'd100;
      divisor = 32'd7;
      sgn = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            n_done++;
            if (first == 0) begin
               first = n;
               q = quotient;
               r = remainder;
            end
         end
         if (n > 33 && busy) late_busy = 1'b1;
         if (n == 9) begin
            start = 1'b1;
            dividend = 32'd50;
            divisor = 32'd5;
         end
         if (n == 10) start = 1'b0;
      end
      n_tests++;
      if (n_done != 1 || first != 33 || q !== 32'd14 || r !== 32'd2 || late_busy) begin
         n_fail++;
         $display("FAIL busy_ignore: dones=%0d at=%0d q=%0d r=%0d late_busy=%b, want 1 at 33 q=14 r=2 late_busy=0",
                  n_done, first, q, r, late_busy);
      end
   endtask

   task automatic test_reset_abort();
      int n_done = 0;
      logic [31:0] q, r;
      logic z;
      int lat;
      bit held;
      dividend = 32'd100;
      divisor = 32'd7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_tests++;
      if ({busy, done, dz, quotient, remainder} !== 67'd0) begin
         n_fail++;
         $display("FAIL reset_abort_state: busy=%b done=%b dz=%b q=%h r=%h, want all 0",
                  busy, done, dz, quotient, remainder);
      end
      rst = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         #1;
         if (done || busy) n_done++;
      end
      n_tests++;
      if (n_done != 0) begin
         n_fail++;
         $display("FAIL reset_abort_quiet: %0d cycles busy/done after abort, want 0", n_done);
      end
      run_div(32'd20, 32'd6, 1'b0, q, r, z, lat, held);
      n_tests++;
      if (q !== 32'd3 || r !== 32'd2 || z !== 1'b0 || lat != 33) begin
         n_fail++;
         $display("FAIL reset_abort_next: got q=%0d r=%0d dz=%b lat=%0d, want q=3 r=2 dz=0 lat=33",
                  q, r, z, lat);
      end
   endtask

   task automatic test_back_to_back();
      int at = 0;
      dividend = 32'd1000;
      divisor = 32'd10;
      sgn = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int n = 1; n <= 40 && !done; n++) begin
         @(posedge clk);
         #1;
      end
      // Raised during the done cycle: ignored there, accepted on the following edge
      start = 1'b1;
      dividend = 32'd77;
      divisor = 32'd5;
      for (int n = 1; n <= 45; n++) begin
         @(posedge clk);
         #1;
         if (n == 2) start = 1'b0;
         if (done) begin
            at = n;
            break;
         end
      end
      n_tests++;
      if (at != 35 || quotient !== 32'd15 || remainder !== 32'd2) begin
         n_fail++;
         $display("FAIL back_to_back: done at %0d q=%0d r=%0d, want 35 q=15 r=2", at, quotient, remainder);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic [31:0] a, b, eq, er, q, r;
      logic s, ez, z;
      int lat;
      bit held;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 3))
            0: b = $urandom_range(0, 15);
            1: b = b >> $urandom_range(0, 31);
            2: a = a >> $urandom_range(0, 31);
            default: ;
         endcase
         s = 1'($urandom_range(0, 1));
         model(a, b, s, eq, er, ez);
         run_div(a, b, s, q, r, z, lat, held);
         n_tests++;
         if (q !== eq || r !== er || z !== ez || lat != 33 || !held) begin
            n_fail++;
            $display("FAIL random_%0d: %h/%h sgn=%b got q=%h r=%h dz=%b lat=%0d held=%b, want q=%h r=%h dz=%b lat=33 held=1",
                     i, a, b, s, q, r, z, lat, held, eq, er, ez);
         end
      end
   endtask

`ifdef DIV_SIGNED_EN
   task automatic test_signed();
      logic [31:0] va [5] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFE7};
      logic [31:0] vb [5] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 32'd0};
      logic        vs [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] eq [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h7FFF_FFFC, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [31:0] er [5] = '{32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFE7};
      logic        ez [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] q, r;
      logic z;
      int lat;
      bit held;
      for (int i = 0; i < 5; i++) begin
         run_div(va[i], vb[i], vs[i], q, r, z, lat, held);
         n_tests++;
         if (q !== eq[i] || r !== er[i] || z !== ez[i] || lat != 33) begin
            n_fail++;
            $display("FAIL signed_%0d: got q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b lat=33",
                     i, q, r, z, lat, eq[i], er[i], ez[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_busy_ignore();
      test_reset_abort();
      test_back_to_back();
      test_random();
`ifdef DIV_SIGNED_EN
      test_signed();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
